// File: rtl/jt6295_adpcm_if.sv
// jt6295_adpcm_if: slot-timing, nibble/attenuation inputs and sample output of the ADPCM decoder.
interface jt6295_adpcm_if;
   logic               cen;
   logic               cen4;
   logic [3:0]         en;
   logic [3:0]         start;
   logic [3:0]         data;
   logic [3:0]         att;
   logic [1:0]         ch;
   logic signed [11:0] sound;
   modport master(output cen, cen4, en, start, data, att, input ch, sound);
   modport slave(input cen, cen4, en, start, data, att, output ch, sound);
endinterface

// File: rtl/jt6295_adpcm.sv
// jt6295_adpcm: four-channel time-multiplexed OKI ADPCM decoder with per-slot attenuation.
module jt6295_adpcm (
   input logic            rst,
   input logic            clk,
   jt6295_adpcm_if.slave  bus
);
   localparam logic [10:0] STEP [0:48] = '{
      11'd16, 11'd17, 11'd19, 11'd21, 11'd23, 11'd25, 11'd28, 11'd31, 11'd34, 11'd37,
      11'd41, 11'd45, 11'd50, 11'd55, 11'd60, 11'd66, 11'd73, 11'd80, 11'd88, 11'd97,
      11'd107, 11'd118, 11'd130, 11'd143, 11'd157, 11'd173, 11'd190, 11'd209, 11'd230, 11'd253,
      11'd279, 11'd307, 11'd337, 11'd371, 11'd408, 11'd449, 11'd494, 11'd544, 11'd598, 11'd658,
      11'd724, 11'd796, 11'd876, 11'd963, 11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552};
   localparam logic [5:0] GAIN [0:8] = '{6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3, 6'd2};
   logic [1:0]         r_ch;
   logic signed [11:0] r_sound;
   logic signed [11:0] r_sig [4];
   logic [5:0]         r_idx [4];
   logic [1:0]         w_k;
   logic [10:0]        w_step;
   logic [12:0]        w_diff;
   logic signed [13:0] w_sum;
   logic signed [11:0] w_sig;
   logic signed [6:0]  w_idx_sum;
   logic [5:0]         w_idx;
   logic [5:0]         w_gain;
   logic signed [16:0] w_mult;
   logic signed [11:0] w_att;
   // cen marks slot 0, so it overrides the free-running counter
   assign w_k    = bus.cen ? 2'd0 : r_ch;
   assign w_step = STEP[r_idx[w_k]];
   assign w_diff = 13'(w_step >> 3)
                 + (bus.data[0] ? 13'(w_step >> 2) : 13'd0)
                 + (bus.data[1] ? 13'(w_step >> 1) : 13'd0)
                 + (bus.data[2] ? 13'(w_step) : 13'd0);
   assign w_sum  = $signed({{2{r_sig[w_k][11]}}, r_sig[w_k]})
                 + (bus.data[3] ? -$signed({1'b0, w_diff}) : $signed({1'b0, w_diff}));
   assign w_sig  = w_sum > 14'sd2047 ? 12'sh7ff : w_sum < -14'sd2048 ? 12'sh800 : w_sum[11:0];
   assign w_idx_sum = $signed({1'b0, r_idx[w_k]})
                    + (bus.data[2] ? $signed({4'b0, bus.data[1:0], 1'b0}) + 7'sd2 : -7'sd1);
   assign w_idx  = w_idx_sum < 7'sd0 ? 6'd0 : w_idx_sum > 7'sd48 ? 6'd48 : w_idx_sum[5:0];
   assign w_gain = bus.att > 4'd8 ? 6'd0 : GAIN[bus.att];
   assign w_mult = 17'(w_sig) * 17'($signed({1'b0, w_gain}));
   assign w_att  = 12'(w_mult >>> 5);
   assign bus.ch    = r_ch;
   assign bus.sound = r_sound;
   always_ff @(posedge clk, posedge rst)
      if (rst) begin
         r_ch    <= 2'd0;
         r_sound <= 12'sd0;
         for (int i = 0; i < 4; i++) begin
            r_sig[i] <= 12'sd0;
            r_idx[i] <= 6'd0;
         end
      end else if (bus.cen4) begin
         r_ch <= w_k + 2'd1;
         if (bus.start[w_k]) begin
            r_sig[w_k] <= 12'sd0;
            r_idx[w_k] <= 6'd0;
            r_sound    <= 12'sd0;
         end else if (bus.en[w_k]) begin
            r_sig[w_k] <= w_sig;
            r_idx[w_k] <= w_idx;
            r_sound    <= w_att;
         end else
            r_sound <= 12'sd0;
      end
endmodule

// File: tb/tb_jt6295_adpcm.sv
// tb_jt6295_adpcm: directed vector table plus saturation sequence for the ADPCM decoder.
module tb_jt6295_adpcm;
   logic rst = 1'b1;
   logic clk = 1'b0;
   jt6295_adpcm_if bus();
   jt6295_adpcm dut (.rst(rst), .clk(clk), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      bit       r;
      bit       cen;
      bit       cen4;
      int       en, start, data, att, snd, ch;
   } vec_t;
   vec_t tv[$];
   int   errors = 0;
   int   checks = 0;
   function automatic void add(bit r, bit cen, bit cen4, int en, int start, int data, int att,
                               int snd, int ch);
      vec_t v;
      v.r = r; v.cen = cen; v.cen4 = cen4; v.en = en; v.start = start;
      v.data = data; v.att = att; v.snd = snd; v.ch = ch;
      tv.push_back(v);
   endfunction
   task automatic check(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic do_reset();
      bus.cen4 = 1'b0;
      bus.cen  = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_sound", int'(bus.sound), 0);
      check("reset_ch", int'(bus.ch), 0);
      rst = 1'b0;
   endtask
   task automatic apply(bit cen, bit cen4, int en, int start, int data, int att);
      bus.cen = cen; bus.cen4 = cen4;
      bus.en = 4'(en); bus.start = 4'(start); bus.data = 4'(data); bus.att = 4'(att);
      @(posedge clk);
      #1;
      bus.cen4 = 1'b0;
      bus.cen  = 1'b0;
   endtask
   initial begin
      bus.cen = 0; bus.cen4 = 0; bus.en = 0; bus.start = 0; bus.data = 0; bus.att = 0;
      // basic step, idx clamp, hold without cen4
      add(1,1,1,1,0,0,0,   2,1);
      add(0,0,0,1,0,7,0,   2,1);
      add(0,1,1,1,0,0,0,   4,1);
      // growth and shrink of step
      add(1,1,1,1,0,7,0,  30,1);
      add(0,1,1,1,0,7,0,  93,1);
      add(0,1,1,1,0,0,0, 102,1);
      add(0,1,1,1,0,8,0,  94,1);
      // attenuation, including floor on negative products
      add(1,1,1,1,0,7,1,  20,1);
      add(0,1,1,1,0,8,2,  13,1);
      add(1,1,1,1,0,15,3,-11,1);
      add(0,1,1,1,0,0,9,   0,1);
      add(0,1,1,1,0,0,0, -23,1);
      add(0,1,1,1,0,8,8,  -2,1);
      add(0,1,1,1,0,0,15,  0,1);
      add(0,1,1,1,0,0,4,  -6,1);
      add(0,1,1,1,0,0,5,  -4,1);
      add(0,1,1,1,0,0,6,  -3,1);
      add(0,1,1,1,0,0,7,  -2,1);
      // four channels, start on ch2, resync from ch2, en off on ch1
      add(1,1,1,15,0,7,0, 30,1);
      add(0,0,1,15,0,1,0,  6,2);
      add(0,0,1,15,0,2,0, 10,3);
      add(0,0,1,15,0,9,0, -6,0);
      add(0,1,1,15,0,0,0, 34,1);
      add(0,0,1,15,0,0,0,  8,2);
      add(0,0,1,15,4,7,0,  0,3);
      add(0,0,1,15,0,0,0, -4,0);
      add(0,1,1,15,0,0,0, 37,1);
      add(0,0,1,15,0,0,0, 10,2);
      add(0,0,1,15,0,0,0,  2,3);
      add(0,0,1,15,0,0,0, -2,0);
      add(0,1,1,15,0,0,0, 40,1);
      add(0,0,1,15,0,0,0, 12,2);
      add(0,1,1,15,0,0,0, 43,1);
      add(0,0,1,13,0,7,0,  0,2);
      add(0,0,1,15,0,0,0,  4,3);
      add(0,0,1,15,0,0,0,  0,0);
      add(0,1,1,15,0,0,0, 45,1);
      add(0,0,1,15,0,0,0, 14,2);
      // reset mid-sequence: first cen4 afterwards is slot 0 even without cen
      add(1,0,1,1,0,0,0,   2,1);
      for (int i = 0; i < tv.size(); i++) begin
         if (tv[i].r) do_reset();
         apply(tv[i].cen, tv[i].cen4, tv[i].en, tv[i].start, tv[i].data, tv[i].att);
         check($sformatf("v%0d_sound", i), int'(bus.sound), tv[i].snd);
         check($sformatf("v%0d_ch", i), int'(bus.ch), tv[i].ch);
      end
      // positive saturation, then full-step negative swing and negative saturation
      do_reset();
      for (int i = 0; i < 12; i++) apply(1, 1, 1, 0, 7, 0);
      check("sat_pos", int'(bus.sound), 2047);
      apply(1, 1, 1, 0, 15, 0);
      check("sat_swing", int'(bus.sound), -863);
      apply(1, 1, 1, 0, 15, 0);
      check("sat_neg", int'(bus.sound), -2048);
      apply(1, 1, 1, 0, 0, 0);
      check("sat_idx48", int'(bus.sound), -2048 + 194);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jt6295_adpcm.md
JT6295_ADPCM -- requirements
Module: jt6295_adpcm

Interface
REQ-001 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: clock.
REQ-003 SHALL have port cen, input, 1 bit: sample-rate enable, coincident with the cen4 of slot 0.
REQ-004 SHALL have port cen4, input, 1 bit: channel-slot enable, four per sample.
REQ-005 SHALL have port en, input, 4 bits: channel k playing, one bit per channel.
REQ-006 SHALL have port start, input, 4 bits: channel k restart decoder state.
REQ-007 SHALL have port data, input, 4 bits: ADPCM nibble for the current slot.
REQ-008 SHALL have port att, input, 4 bits: attenuation code for the current slot.
REQ-009 SHALL have port ch, output, 2 bits: current slot number, used by upstream for nibble/att fetch.
REQ-010 SHALL have port sound, output, 12 bits, signed: decoded, attenuated sample of the last processed slot.

Function
REQ-011 SHALL hold per channel k (0..3) a 12-bit signed signal[k] and a 6-bit step index idx[k] (range 0..48).
REQ-012 Slot counter ch SHALL advance by 1 on each cen4 and wrap 3->0.
REQ-013 If cen and cen4 are both high, the slot processed SHALL be 0 and ch SHALL become 1, regardless of the prior ch (resync).
REQ-014 Processing SHALL occur only on clk edges with cen4=1; all state and outputs SHALL hold otherwise.
REQ-015 Processed slot k = ch, or 0 under REQ-013; data and att SHALL be sampled on that same edge.
REQ-016 The step SHALL be looked up from the OKI 49-entry table: step(i) = 16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552.
REQ-017 The difference SHALL be diff = step/8 + (data[0]?step/4:0) + (data[1]?step/2:0) + (data[2]?step:0), each term truncated integer division, computed at >=13-bit width.
REQ-018 The new signal SHALL be signal[k]-diff if data[3]=1, else signal[k]+diff, saturated to -2048..+2047.
REQ-019 The new idx SHALL be idx[k]+{-1,-1,-1,-1,+2,+4,+6,+8}[data[2:0]], saturated to 0..48.
REQ-020 Gain for att 0..8 SHALL be {32,22,16,11,8,6,4,3,2}; att>=9 SHALL give gain 0.
REQ-021 Attenuated output SHALL be (new signal * gain) >>> 5, arithmetic shift, truncating toward minus infinity.
REQ-022 Slot priority SHALL be: start[k]=1 clears signal[k]=0 and idx[k]=0 and sets sound=0, regardless of en[k].
REQ-023 Otherwise, with en[k]=1: signal[k]/idx[k] SHALL update per REQ-018/019, and sound SHALL be set to the REQ-021 value.
REQ-024 Otherwise (en[k]=0): signal[k]/idx[k] SHALL hold, and sound SHALL be 0.
REQ-025 sound SHALL be registered, valid from the clock after the cen4 edge, held until the next cen4 edge; latency is one clk from data sampling.
REQ-026 Channels not being processed SHALL never change state.

Reset
REQ-027 While rst=1, all signal[k]=0, all idx[k]=0, ch=0 and sound=0 SHALL hold.
REQ-028 rst asserted mid-sample SHALL abandon the slot sequence, and the first cen4 after release SHALL process slot 0.

Verification
REQ-029 After reset, en=0001, att=0, data=0 at slot 0 -> sound=+2, idx[0]=0 (clamped from -1).
REQ-030 After reset, data=7 at slot 0 -> diff=2+4+8+16=30, sound=+30, idx[0]=8; next slot-0 data=7 -> step 34, diff=4+8+17+34=63, sound=+93, idx[0]=16.
REQ-031 Repeated data=7 on channel 0 -> signal saturates at +2047 and idx at 48; then data=F -> signal=2047-(194+388+776+1552)=-863, sound=-863.
REQ-032 signal[2]=+1000 with att=2 -> sound=+500; with att=8 -> +62; with att=9 -> 0 while signal[2] still updates.
REQ-033 start=0100 pulsed while ch 2 is playing -> that slot gives sound=0 and idx[2]=0, and channels 0, 1, 3 are unchanged.
REQ-034 cen asserted with cen4 while ch=2 -> slot processed as 0, ch=1 afterwards.
